// File: rtl/scard_io_sequencer_if.sv
// Signal bundle between the smartcard I/O sequencer, the host byte port
// and the async receiver/transmitter pair.
interface scard_io_sequencer_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_ready;

    logic       txu_start;
    logic [7:0] txu_data;
    logic       txu_busy;

    logic       rxu_ready;
    logic [7:0] rxu_data;
    logic       rxu_error;
    logic       rxu_idle;

    logic       rx_en;
    logic       io_dir;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ack;
    logic       rx_overrun;
    logic       rx_frame_err;
    logic       wwt_timeout;

    // Sequencer side
    modport master (
        input  tx_valid, tx_data, tx_last, txu_busy,
        input  rxu_ready, rxu_data, rxu_error, rxu_idle, rx_ack,
        output tx_ready, txu_start, txu_data, rx_en, io_dir,
        output rx_valid, rx_data, rx_overrun, rx_frame_err, wwt_timeout
    );

    // Host plus receiver/transmitter side
    modport slave (
        output tx_valid, tx_data, tx_last, txu_busy,
        output rxu_ready, rxu_data, rxu_error, rxu_idle, rx_ack,
        input  tx_ready, txu_start, txu_data, rx_en, io_dir,
        input  rx_valid, rx_data, rx_overrun, rx_frame_err, wwt_timeout
    );
endinterface

// File: rtl/scard_io_sequencer.sv
// Half-duplex sequencer for the smartcard I/O line: transmit/listen control,
// guard and turnaround timing, waiting-time supervision and a one-byte receive buffer.
module scard_io_sequencer #(
    parameter int GUARD_ETU = 2,
    parameter int TURN_ETU  = 16,
    parameter int WWT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 etu_tick,
    input  logic [7:0]           cfg_egt,
    input  logic [WWT_WIDTH-1:0] cfg_wwt,
    scard_io_sequencer_if.master io
);

    localparam int TURN_W = $clog2(TURN_ETU + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_BUSY,
        ST_GUARD,
        ST_RX_WAIT
    } state_t;

    state_t               state_q, state_d;
    logic [TURN_W-1:0]    turn_cnt_q, turn_cnt_d;
    logic [8:0]           guard_cnt_q, guard_cnt_d;
    logic [WWT_WIDTH-1:0] wwt_cnt_q, wwt_cnt_d;
    logic [7:0]           tx_byte_q, tx_byte_d;
    logic                 tx_last_q, tx_last_d;
    logic                 rx_valid_q, rx_valid_d;
    logic [7:0]           rx_data_q, rx_data_d;
    logic                 rx_overrun_q, rx_overrun_d;
    logic                 rx_frame_err_q, rx_frame_err_d;
    logic                 wwt_timeout_q, wwt_timeout_d;

    logic rx_en;
    logic turn_ok;
    logic tx_ready;
    logic accept;
    logic rx_take;
    logic err_take;
    logic wwt_hit;

    assign rx_en    = (state_q == ST_IDLE) || (state_q == ST_RX_WAIT);
    assign turn_ok  = (turn_cnt_q == TURN_W'(TURN_ETU));
    assign tx_ready = rx_en && turn_ok && io.rxu_idle;
    assign accept   = io.tx_valid && tx_ready;
    assign rx_take  = io.rxu_ready && rx_en;
    assign err_take = io.rxu_error && rx_en;
    // The tick that brings the count up to cfg_wwt is the expiring one
    assign wwt_hit  = (cfg_wwt != '0) && (wwt_cnt_q == cfg_wwt - WWT_WIDTH'(1)) && etu_tick;

    assign io.tx_ready     = tx_ready;
    assign io.rx_en        = rx_en;
    assign io.txu_start    = (state_q == ST_LOAD);
    assign io.io_dir       = (state_q == ST_LOAD) || (state_q == ST_BUSY);
    assign io.txu_data     = tx_byte_q;
    assign io.rx_valid     = rx_valid_q;
    assign io.rx_data      = rx_data_q;
    assign io.rx_overrun   = rx_overrun_q;
    assign io.rx_frame_err = rx_frame_err_q;
    assign io.wwt_timeout  = wwt_timeout_q;

    always_comb begin
        state_d       = state_q;
        guard_cnt_d   = guard_cnt_q;
        wwt_cnt_d     = wwt_cnt_q;
        tx_byte_d     = tx_byte_q;
        tx_last_d     = tx_last_q;
        wwt_timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_LOAD;
                    tx_byte_d = io.tx_data;
                    tx_last_d = io.tx_last;
                end
            end
            ST_LOAD: begin
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (!io.txu_busy) begin
                    state_d     = ST_GUARD;
                    guard_cnt_d = {1'b0, cfg_egt} + 9'(GUARD_ETU);
                end
            end
            ST_GUARD: begin
                if (guard_cnt_q == 9'd0) begin
                    state_d   = tx_last_q ? ST_RX_WAIT : ST_IDLE;
                    wwt_cnt_d = '0;
                end else if (etu_tick) begin
                    guard_cnt_d = guard_cnt_q - 9'd1;
                end
            end
            ST_RX_WAIT: begin
                // A new host command wins over a simultaneous expiry
                if (accept) begin
                    state_d   = ST_LOAD;
                    tx_byte_d = io.tx_data;
                    tx_last_d = io.tx_last;
                end else if (rx_take || err_take) begin
                    wwt_cnt_d = '0;
                end else if (wwt_hit) begin
                    state_d       = ST_IDLE;
                    wwt_timeout_d = 1'b1;
                end else if (etu_tick) begin
                    wwt_cnt_d = wwt_cnt_q + WWT_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        turn_cnt_d = turn_cnt_q;
        if (rx_take || err_take) begin
            turn_cnt_d = '0;
        end else if (etu_tick && !turn_ok) begin
            turn_cnt_d = turn_cnt_q + TURN_W'(1);
        end
    end

    // A byte arriving together with the host ack replaces the old one cleanly
    always_comb begin
        rx_valid_d     = rx_valid_q;
        rx_data_d      = rx_data_q;
        rx_overrun_d   = 1'b0;
        rx_frame_err_d = err_take;
        if (rx_take) begin
            rx_valid_d   = 1'b1;
            rx_data_d    = io.rxu_data;
            rx_overrun_d = rx_valid_q && !io.rx_ack;
        end else if (io.rx_ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            turn_cnt_q     <= TURN_W'(TURN_ETU);
            guard_cnt_q    <= '0;
            wwt_cnt_q      <= '0;
            tx_byte_q      <= '0;
            tx_last_q      <= 1'b0;
            rx_valid_q     <= 1'b0;
            rx_data_q      <= '0;
            rx_overrun_q   <= 1'b0;
            rx_frame_err_q <= 1'b0;
            wwt_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            turn_cnt_q     <= turn_cnt_d;
            guard_cnt_q    <= guard_cnt_d;
            wwt_cnt_q      <= wwt_cnt_d;
            tx_byte_q      <= tx_byte_d;
            tx_last_q      <= tx_last_d;
            rx_valid_q     <= rx_valid_d;
            rx_data_q      <= rx_data_d;
            rx_overrun_q   <= rx_overrun_d;
            rx_frame_err_q <= rx_frame_err_d;
            wwt_timeout_q  <= wwt_timeout_d;
        end
    end

endmodule

// File: tb/tb_scard_io_sequencer.sv
// Scenario bench for scard_io_sequencer: transmit bytes are scoreboarded against
// captured txu_start pulses, received bytes against a one-entry buffer model.
module tb_scard_io_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        etu_tick = 1'b0;
    logic [7:0]  cfg_egt = 8'd3;
    logic [15:0] cfg_wwt = 16'd0;

    int checks = 0;
    int errors = 0;

    scard_io_sequencer_if io();

    scard_io_sequencer #(
        .GUARD_ETU(2),
        .TURN_ETU (16),
        .WWT_WIDTH(16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .etu_tick(etu_tick),
        .cfg_egt (cfg_egt),
        .cfg_wwt (cfg_wwt),
        .io      (io)
    );

    always #5 clk = ~clk;

    logic [7:0] tx_exp_q[$];
    logic [7:0] rx_exp_q[$];
    bit         m_valid = 1'b0;
    int         exp_ovr = 0;
    int         tx_rd = 0;

    logic [7:0] obs_tx[256];
    int         obs_tx_n = 0;
    int         ovr_n = 0;
    int         ferr_n = 0;
    int         tmo_n = 0;

    // Pulse capture away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (io.txu_start && obs_tx_n < 256) begin
                obs_tx[obs_tx_n] = io.txu_data;
                obs_tx_n++;
            end
            if (io.rx_overrun)   ovr_n++;
            if (io.rx_frame_err) ferr_n++;
            if (io.wwt_timeout)  tmo_n++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic etu();
        etu_tick = 1'b1;
        cyc();
        etu_tick = 1'b0;
        cyc();
        cyc();
    endtask

    // Drive one receiver byte and update the buffer model
    task automatic rx_push(input logic [7:0] d, input bit ack, input bit tick);
        if (m_valid) begin
            void'(rx_exp_q.pop_front());
            if (!ack) exp_ovr++;
        end
        rx_exp_q.push_back(d);
        m_valid = 1'b1;
        io.rxu_ready = 1'b1;
        io.rxu_data  = d;
        io.rx_ack    = ack;
        etu_tick     = tick;
        cyc();
        io.rxu_ready = 1'b0;
        io.rx_ack    = 1'b0;
        etu_tick     = 1'b0;
    endtask

    task automatic rx_consume();
        io.rx_ack = 1'b1;
        cyc();
        io.rx_ack = 1'b0;
        if (m_valid) void'(rx_exp_q.pop_front());
        m_valid = 1'b0;
        checks++;
        if (io.rx_valid !== 1'b0)
            $display("[TB] FAIL rx_ack_clear: rx_valid=%b expected 0", io.rx_valid);
        if (io.rx_valid !== 1'b0) errors++;
    endtask

    // Accepts a byte, models the transmitter busy for busy_etus, ends in GUARD
    task automatic send_byte(input logic [7:0] d, input bit last, input int busy_etus, input bit inject);
        int n;
        logic [7:0] e;
        n = 0;
        while (!io.tx_ready && n < 300) begin
            cyc();
            n++;
        end
        checks++;
        if (!io.tx_ready) begin
            errors++;
            $display("[TB] FAIL tx_ready_wait: tx_ready=%b expected 1 within 300 cycles", io.tx_ready);
        end
        io.tx_valid = 1'b1;
        io.tx_data  = d;
        io.tx_last  = last;
        tx_exp_q.push_back(d);
        cyc();
        io.tx_valid = 1'b0;
        checks++;
        if (io.txu_start !== 1'b1 || io.io_dir !== 1'b1 || io.rx_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_outputs: start/dir/rx_en=%b%b%b expected 110",
                     io.txu_start, io.io_dir, io.rx_en);
        end
        io.txu_busy = 1'b1;
        cyc();
        checks++;
        if (obs_tx_n <= tx_rd || tx_exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL txu_data: no txu_start captured, expected %0h", d);
        end else begin
            e = tx_exp_q.pop_front();
            if (obs_tx[tx_rd] !== e) begin
                errors++;
                $display("[TB] FAIL txu_data: got %0h expected %0h", obs_tx[tx_rd], e);
            end
            tx_rd++;
        end
        for (int i = 0; i < busy_etus; i++) begin
            etu();
            if (inject && i == 0) begin
                io.rxu_ready = 1'b1;
                io.rxu_data  = 8'h77;
                io.rxu_error = 1'b1;
                cyc();
                io.rxu_ready = 1'b0;
                io.rxu_error = 1'b0;
            end
        end
        checks++;
        if (io.io_dir !== 1'b1) begin
            errors++;
            $display("[TB] FAIL io_dir_busy: got %b expected 1", io.io_dir);
        end
        io.txu_busy = 1'b0;
        cyc();
        checks++;
        if (io.io_dir !== 1'b0) begin
            errors++;
            $display("[TB] FAIL io_dir_guard: got %b expected 0", io.io_dir);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) cyc();
        checks++;
        if (io.io_dir !== 1'b0 || io.rx_en !== 1'b1 || io.tx_ready !== 1'b1 || io.txu_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: dir/rx_en/ready/start=%b%b%b%b expected 0110",
                     io.io_dir, io.rx_en, io.tx_ready, io.txu_start);
        end
        checks++;
        if (io.rx_valid !== 1'b0 || io.rx_overrun !== 1'b0 || io.rx_frame_err !== 1'b0 || io.wwt_timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_status: valid/ovr/ferr/tmo=%b%b%b%b expected 0000",
                     io.rx_valid, io.rx_overrun, io.rx_frame_err, io.wwt_timeout);
        end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_single_byte();
        cfg_egt = 8'd3;
        send_byte(8'hA5, 1'b0, 10, 1'b0);
        repeat (4) etu();
        checks++;
        if (io.tx_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL guard_4_ticks: tx_ready=%b expected 0", io.tx_ready);
        end
        etu();
        checks++;
        if (io.tx_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL guard_5_ticks: tx_ready=%b expected 1", io.tx_ready);
        end
    endtask

    task automatic test_timeout();
        int base;
        cfg_wwt = 16'd20;
        base = tmo_n;
        send_byte(8'hC3, 1'b1, 2, 1'b0);
        repeat (5) etu();
        repeat (19) etu();
        checks++;
        if (tmo_n !== base) begin
            errors++;
            $display("[TB] FAIL wwt_early: timeouts=%0d expected %0d", tmo_n, base);
        end
        etu();
        checks++;
        if (tmo_n !== base + 1 || io.rx_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wwt_expiry: timeouts=%0d rx_valid=%b expected %0d and 0",
                     tmo_n, io.rx_valid, base + 1);
        end
        repeat (25) etu();
        checks++;
        if (tmo_n !== base + 1) begin
            errors++;
            $display("[TB] FAIL wwt_idle: timeouts=%0d expected %0d", tmo_n, base + 1);
        end
    endtask

    task automatic test_response();
        int base_tmo;
        int base_obs;
        logic [7:0] e;
        base_tmo = tmo_n;
        send_byte(8'h96, 1'b1, 2, 1'b0);
        repeat (5) etu();
        repeat (6) etu();
        rx_push(8'h3B, 1'b0, 1'b1);
        io.tx_valid = 1'b1;
        io.tx_data  = 8'h5A;
        io.tx_last  = 1'b0;
        tx_exp_q.push_back(8'h5A);
        base_obs = obs_tx_n;
        checks++;
        if (io.rx_valid !== 1'b1 || io.rx_data !== rx_exp_q[0]) begin
            errors++;
            $display("[TB] FAIL rx_response: valid=%b data=%0h expected 1 and %0h",
                     io.rx_valid, io.rx_data, rx_exp_q[0]);
        end
        checks++;
        if (io.tx_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL turn_hold_start: tx_ready=%b expected 0", io.tx_ready);
        end
        repeat (15) etu();
        checks++;
        if (io.tx_ready !== 1'b0 || obs_tx_n !== base_obs || tmo_n !== base_tmo) begin
            errors++;
            $display("[TB] FAIL turn_hold_15: ready=%b starts=%0d tmo=%0d expected 0 %0d %0d",
                     io.tx_ready, obs_tx_n, tmo_n, base_obs, base_tmo);
        end
        etu_tick = 1'b1;
        cyc();
        etu_tick = 1'b0;
        checks++;
        if (io.tx_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL turn_release: tx_ready=%b expected 1", io.tx_ready);
        end
        cyc();
        io.tx_valid = 1'b0;
        checks++;
        if (io.txu_start !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rxwait_accept: txu_start=%b expected 1", io.txu_start);
        end
        rx_consume();
        checks++;
        if (obs_tx_n <= tx_rd || tx_exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL txu_data_rxwait: no txu_start captured, expected 5a");
        end else begin
            e = tx_exp_q.pop_front();
            if (obs_tx[tx_rd] !== e) begin
                errors++;
                $display("[TB] FAIL txu_data_rxwait: got %0h expected %0h", obs_tx[tx_rd], e);
            end
            tx_rd++;
        end
        cyc();
        repeat (5) etu();
        checks++;
        if (tmo_n !== base_tmo || io.tx_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL after_response: tmo=%0d ready=%b expected %0d and 1",
                     tmo_n, io.tx_ready, base_tmo);
        end
    endtask

    task automatic test_overrun();
        rx_push(8'h11, 1'b0, 1'b0);
        rx_push(8'h22, 1'b0, 1'b0);
        cyc();
        checks++;
        if (ovr_n !== exp_ovr || io.rx_data !== rx_exp_q[0]) begin
            errors++;
            $display("[TB] FAIL overrun_pulse: overruns=%0d data=%0h expected %0d and %0h",
                     ovr_n, io.rx_data, exp_ovr, rx_exp_q[0]);
        end
        rx_consume();
        rx_push(8'h11, 1'b0, 1'b0);
        rx_push(8'h22, 1'b1, 1'b0);
        cyc();
        checks++;
        if (ovr_n !== exp_ovr || io.rx_valid !== 1'b1 || io.rx_data !== rx_exp_q[0]) begin
            errors++;
            $display("[TB] FAIL ack_no_overrun: overruns=%0d valid=%b data=%0h expected %0d 1 %0h",
                     ovr_n, io.rx_valid, io.rx_data, exp_ovr, rx_exp_q[0]);
        end
        rx_consume();
    endtask

    task automatic test_ignored_rx();
        int base_ferr;
        repeat (16) etu();
        base_ferr = ferr_n;
        send_byte(8'h3C, 1'b0, 4, 1'b1);
        io.rxu_ready = 1'b1;
        io.rxu_data  = 8'h78;
        cyc();
        io.rxu_ready = 1'b0;
        repeat (5) etu();
        checks++;
        if (io.rx_valid !== 1'b0 || io.tx_ready !== 1'b1 || ferr_n !== base_ferr) begin
            errors++;
            $display("[TB] FAIL ignored_rx: valid=%b ready=%b ferr=%0d expected 0 1 %0d",
                     io.rx_valid, io.tx_ready, ferr_n, base_ferr);
        end
        io.rxu_error = 1'b1;
        cyc();
        io.rxu_error = 1'b0;
        cyc();
        checks++;
        if (ferr_n !== base_ferr + 1 || io.tx_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL frame_err_idle: ferr=%0d ready=%b expected %0d and 0",
                     ferr_n, io.tx_ready, base_ferr + 1);
        end
        repeat (15) etu();
        checks++;
        if (io.tx_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ferr_turn_15: tx_ready=%b expected 0", io.tx_ready);
        end
        etu();
        checks++;
        if (io.tx_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ferr_turn_16: tx_ready=%b expected 1", io.tx_ready);
        end
    endtask

    task automatic test_reset_mid_busy();
        logic [7:0] e;
        io.tx_valid = 1'b1;
        io.tx_data  = 8'hE7;
        io.tx_last  = 1'b0;
        tx_exp_q.push_back(8'hE7);
        cyc();
        io.tx_valid = 1'b0;
        io.txu_busy = 1'b1;
        cyc();
        cyc();
        checks++;
        if (io.io_dir !== 1'b1) begin
            errors++;
            $display("[TB] FAIL io_dir_pre_reset: got %b expected 1", io.io_dir);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (io.io_dir !== 1'b0) begin
            errors++;
            $display("[TB] FAIL io_dir_async_reset: got %b expected 0", io.io_dir);
        end
        io.txu_busy = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        checks++;
        if (io.tx_ready !== 1'b1 || io.rx_en !== 1'b1 || io.io_dir !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_reset: ready/rx_en/dir=%b%b%b expected 110",
                     io.tx_ready, io.rx_en, io.io_dir);
        end
        checks++;
        if (obs_tx_n <= tx_rd || tx_exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL txu_data_reset: no txu_start captured, expected e7");
        end else begin
            e = tx_exp_q.pop_front();
            if (obs_tx[tx_rd] !== e) begin
                errors++;
                $display("[TB] FAIL txu_data_reset: got %0h expected %0h", obs_tx[tx_rd], e);
            end
            tx_rd++;
        end
    endtask

    task automatic test_scoreboard_drained();
        checks++;
        if (tx_exp_q.size() != 0 || obs_tx_n != tx_rd) begin
            errors++;
            $display("[TB] FAIL tx_scoreboard: pending=%0d starts=%0d expected 0 and %0d",
                     tx_exp_q.size(), obs_tx_n, tx_rd);
        end
    endtask

    initial begin
        io.tx_valid  = 1'b0;
        io.tx_data   = 8'h00;
        io.tx_last   = 1'b0;
        io.txu_busy  = 1'b0;
        io.rxu_ready = 1'b0;
        io.rxu_data  = 8'h00;
        io.rxu_error = 1'b0;
        io.rxu_idle  = 1'b1;
        io.rx_ack    = 1'b0;

        test_reset();
        test_single_byte();
        test_timeout();
        test_response();
        test_overrun();
        test_ignored_rx();
        test_reset_mid_busy();
        test_scoreboard_drained();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
